// File: rtl/key_sweep_ctrl_pkg.sv
// Shared definitions for the key sweep controller and its decoder pairing.
package key_sweep_ctrl_pkg;

  // The decoder runs a fixed number of rounds; its valid flag is sampled
  // one cycle after the last round, hence rounds + 1.
  localparam int DEC_ROUNDS      = 32;
  localparam int DEC_LATENCY_DEF = DEC_ROUNDS + 1;

  // Candidate key width, matching the decoder key port.
  localparam int KEY_W_DEF = 48;

  // Wait counter width; it covers latencies up to 255.
  localparam int LAT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } sweep_state_t;

endpackage

// File: rtl/key_sweep_ctrl_lat_timer.sv
// Down-counter that spaces each decoder start pulse from its sample cycle.
module lat_timer
  import key_sweep_ctrl_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; the counter parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ena) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));

endmodule

// File: rtl/key_sweep_ctrl.sv
// Brute-force key sweep: feeds candidate keys lo..hi to a fixed-latency
// decoder one at a time and stops on the first plaintext match.
module key_sweep_ctrl
  import key_sweep_ctrl_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int DEC_LATENCY = DEC_LATENCY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             go,
  input  logic             abort,
  input  logic [63:0]      cipher,
  input  logic [KEY_W-1:0] key_lo,
  input  logic [KEY_W-1:0] key_hi,
  output logic             dec_start,
  output logic [63:0]      dec_data,
  output logic [KEY_W-1:0] dec_key,
  input  logic             dec_valid,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] key_found
);

  // ISSUE itself is the first latency cycle, so WAIT holds LAT-1 cycles
  // and CHECK lands exactly DEC_LATENCY cycles after the start pulse.
  localparam logic [LAT_W-1:0] LOAD_VAL     = LAT_W'(DEC_LATENCY - 1);
  localparam bit               DIRECT_CHECK = (DEC_LATENCY == 1);

  sweep_state_t     state;
  logic [KEY_W-1:0] hi_q;
  logic             tmr_zero;
  logic             tmr_last;

  lat_timer #(.W(LAT_W)) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .load     (state == S_ISSUE),
    .load_val (LOAD_VAL),
    .dec      (state == S_WAIT),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  // Sweep sequencer; every output is registered and frozen while ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hi_q      <= '0;
      dec_start <= 1'b0;
      dec_data  <= '0;
      dec_key   <= '0;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      key_found <= '0;
    end else if (ena) begin
      unique case (state)
        S_IDLE, S_DONE: begin
          // go beats abort here; abort alone is meaningless when not busy.
          if (go) begin
            dec_data  <= cipher;
            hi_q      <= key_hi;
            dec_key   <= key_lo;
            found     <= 1'b0;
            key_found <= '0;
            if (key_lo > key_hi) begin
              // Empty range: report exhaustion without touching the decoder.
              state     <= S_DONE;
              exhausted <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              exhausted <= 1'b0;
              dec_start <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          dec_start <= 1'b0;
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DIRECT_CHECK ? S_CHECK : S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tmr_last || tmr_zero) begin
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          // Abort wins even over a match seen in the same cycle.
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (dec_valid) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            found     <= 1'b1;
            key_found <= dec_key;
          end else if (dec_key == hi_q) begin
            // Compare before incrementing so an all-ones upper bound never wraps.
            state     <= S_DONE;
            busy      <= 1'b0;
            exhausted <= 1'b1;
          end else begin
            state     <= S_ISSUE;
            dec_key   <= dec_key + 1'b1;
            dec_start <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          dec_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// Bench for key_sweep_ctrl with a fixed-latency stub decoder that matches
// only one key. A cycle-level model derived from attempt arithmetic is
// compared against the DUT on every falling edge.
module tb_key_sweep_ctrl;

  localparam int          KW    = 48;
  localparam int          LAT   = 33;
  localparam int          ATT   = LAT + 1;
  localparam logic [47:0] MATCH = 48'h5;
  localparam logic [47:0] ONES  = '1;
  localparam int          BUD   = 40 * ATT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [63:0]   cipher = '0;
  logic [KW-1:0] key_lo = '0;
  logic [KW-1:0] key_hi = '0;
  logic          dec_start;
  logic [63:0]   dec_data;
  logic [KW-1:0] dec_key;
  logic          dec_valid;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic [KW-1:0] key_found;

  key_sweep_ctrl #(.KEY_W(KW), .DEC_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .go        (go),
    .abort     (abort),
    .cipher    (cipher),
    .key_lo    (key_lo),
    .key_hi    (key_hi),
    .dec_start (dec_start),
    .dec_data  (dec_data),
    .dec_key   (dec_key),
    .dec_valid (dec_valid),
    .busy      (busy),
    .found     (found),
    .exhausted (exhausted),
    .key_found (key_found)
  );

  always #5 clk = ~clk;

  // Stub decoder: valid is raised LAT enabled cycles after the start pulse,
  // and only when the key presented at start was MATCH.
  bit         stub_en = 1'b1;
  logic [8:0] st_cnt;
  logic       st_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt   <= '0;
      st_match <= 1'b0;
    end else if (ena) begin
      if (dec_start) begin
        st_cnt   <= 9'd1;
        st_match <= stub_en && (dec_key == MATCH);
      end else if (st_cnt == 9'(LAT)) begin
        st_cnt <= '0;
      end else if (st_cnt != '0) begin
        st_cnt <= st_cnt + 9'd1;
      end
    end
  end

  assign dec_valid = (st_cnt == 9'(LAT)) && st_match;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 sweeping, 2 done. While sweeping, m_k counts
  // enabled edges since the go edge; each attempt spans ATT of them.
  int          m_mode = 0;
  longint      m_k, m_n;
  logic [47:0] m_lo = '0, m_key = '0, m_kf = '0;
  logic [63:0] m_data = '0;
  bit          m_hit, m_found = 0, m_exh = 0;
  logic [47:0] pulses[$];
  logic        ds_q = 1'b0;

  // Inputs only change after the falling edge, so at this edge they still
  // hold the values the preceding rising edge sampled.
  initial forever begin
    logic [47:0] e_key;
    bit          e_start, e_busy;
    @(negedge clk);
    if (rst) begin
      m_mode = 0; m_lo = '0; m_key = '0; m_kf = '0; m_data = '0;
      m_found = 0; m_exh = 0;
    end else if (ena) begin
      if (m_mode != 1) begin
        if (go) begin
          m_data = cipher; m_lo = key_lo; m_key = key_lo;
          m_found = 0; m_kf = '0;
          if (key_lo > key_hi) begin
            m_mode = 2; m_exh = 1;
          end else begin
            m_hit = stub_en && (MATCH >= key_lo) && (MATCH <= key_hi);
            m_n   = m_hit ? longint'(MATCH - key_lo) + 1 : longint'(key_hi - key_lo) + 1;
            m_mode = 1; m_k = 0; m_exh = 0;
          end
        end
      end else if (abort) begin
        m_mode = 0;
        m_key  = m_lo + 48'(m_k / ATT);
      end else begin
        m_k++;
        if (m_k == m_n * ATT) begin
          m_mode  = 2;
          m_key   = m_lo + 48'(m_n - 1);
          m_found = m_hit;
          m_exh   = !m_hit;
          m_kf    = m_hit ? MATCH : '0;
        end
      end
    end

    e_busy  = (m_mode == 1);
    e_start = e_busy && (m_k % ATT == 0);
    e_key   = e_busy ? m_lo + 48'(m_k / ATT) : m_key;
    vectors++;
    if (dec_start !== e_start || busy !== e_busy || dec_key !== e_key ||
        found !== (m_found && !e_busy) || exhausted !== (m_exh && !e_busy) ||
        key_found !== (e_busy ? 48'h0 : m_kf) || dec_data !== m_data) begin
      errors++;
      $display("FAIL cycle t=%0t: got start=%b busy=%b key=%0h fnd=%b exh=%b kf=%0h data=%0h expected start=%b busy=%b key=%0h fnd=%b exh=%b kf=%0h data=%0h",
               $time, dec_start, busy, dec_key, found, exhausted, key_found, dec_data,
               e_start, e_busy, e_key, m_found && !e_busy, m_exh && !e_busy,
               e_busy ? 48'h0 : m_kf, m_data);
    end

    if (dec_start && !ds_q) pulses.push_back(dec_key);
    ds_q = dec_start;
  end

  // Optional 1/0 ena pattern during a sweep.
  bit tog_en = 0;
  initial forever begin
    @(negedge clk);
    #1;
    if (tog_en) ena = ~ena;
  end

  // Present one go for exactly one rising edge; returns just after it.
  task automatic launch(input logic [47:0] lo, input logic [47:0] hi,
                        input logic [63:0] c, input bit ab);
    @(negedge clk); #1;
    cipher = c; key_lo = lo; key_hi = hi; go = 1'b1; abort = ab; ena = 1'b1;
    pulses.delete();
    @(negedge clk); #2;
    go = 1'b0; abort = 1'b0;
  endtask

  // Run a sweep to completion; cyc counts rising edges from the go edge on.
  task automatic sweep(input logic [47:0] lo, input logic [47:0] hi,
                       input logic [63:0] c, input bit ab, input bit tog,
                       output int cyc);
    launch(lo, hi, c, ab);
    if (tog) begin ena = 1'b0; tog_en = 1; end
    cyc = 1;
    while (busy && cyc < BUD) begin
      @(posedge clk);
      cyc++;
      @(negedge clk); #2;
    end
    tog_en = 0; ena = 1'b1;
    if (busy) chk("sweep_timeout", 64'(busy), 64'h0);
  endtask

  task automatic wait_pulses(input int n);
    int t = 0;
    while (pulses.size() < n && t < BUD) begin
      @(negedge clk); #2;
      t++;
    end
    chk("pulse_wait", 64'(pulses.size()), 64'(n));
  endtask

  initial begin
    int cyc;

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_start", 64'(dec_start), 64'h0);
    chk("rst_found", 64'(found), 64'h0);
    chk("rst_exh", 64'(exhausted), 64'h0);
    chk("rst_key", 64'(dec_key), 64'h0);
    chk("rst_data", dec_data, 64'h0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Match at key 5 within 0..F
    stub_en = 1;
    sweep(48'h0, 48'hF, 64'h0123_4567_89AB_CDEF, 0, 0, cyc);
    chk("A_cycles", 64'(cyc), 64'd205);
    chk("A_pulses", 64'(pulses.size()), 64'd6);
    chk("A_found", 64'(found), 64'h1);
    chk("A_exh", 64'(exhausted), 64'h0);
    chk("A_keyfound", 64'(key_found), 64'h5);
    chk("A_data", dec_data, 64'h0123_4567_89AB_CDEF);

    // No match over 3..5
    stub_en = 0;
    sweep(48'h3, 48'h5, 64'hDEAD_BEEF_0000_0001, 0, 0, cyc);
    chk("B_exh", 64'(exhausted), 64'h1);
    chk("B_found", 64'(found), 64'h0);
    chk("B_pulses", 64'(pulses.size()), 64'd3);
    if (pulses.size() == 3) begin
      chk("B_key0", 64'(pulses[0]), 64'h3);
      chk("B_key1", 64'(pulses[1]), 64'h4);
      chk("B_key2", 64'(pulses[2]), 64'h5);
    end
    chk("B_cycles", 64'(cyc), 64'd103);

    // Top of key space, go and abort together: go wins, no wrap to zero
    sweep(48'hFFFF_FFFF_FFFE, ONES, 64'h55, 1, 0, cyc);
    chk("C_exh", 64'(exhausted), 64'h1);
    chk("C_pulses", 64'(pulses.size()), 64'd2);
    if (pulses.size() == 2) chk("C_key1", 64'(pulses[1]), 64'(ONES));
    chk("C_lastkey", 64'(dec_key), 64'(ONES));
    chk("C_cycles", 64'(cyc), 64'd69);

    // Empty range
    sweep(48'h9, 48'h4, 64'h77, 0, 0, cyc);
    chk("D_cycles", 64'(cyc), 64'd1);
    chk("D_pulses", 64'(pulses.size()), 64'd0);
    chk("D_exh", 64'(exhausted), 64'h1);
    // abort in DONE is ignored
    @(negedge clk); #1; abort = 1'b1;
    @(negedge clk); #2; abort = 1'b0;
    chk("D_abort_ignored", 64'(exhausted), 64'h1);

    // Abort during WAIT of attempt 2, with a stray go while busy
    stub_en = 1;
    launch(48'h0, 48'hF, 64'hA5A5, 0);
    wait_pulses(2);
    go = 1'b1; key_lo = 48'h7;
    @(negedge clk); #2; go = 1'b0;
    repeat (2) @(negedge clk);
    #1; abort = 1'b1;
    @(negedge clk); #2; abort = 1'b0;
    chk("E_busy", 64'(busy), 64'h0);
    chk("E_found", 64'(found), 64'h0);
    chk("E_exh", 64'(exhausted), 64'h0);
    chk("E_start", 64'(dec_start), 64'h0);
    chk("E_key", 64'(dec_key), 64'h1);

    // Reset during WAIT of attempt 2
    launch(48'h0, 48'hF, 64'hA5A5, 0);
    wait_pulses(2);
    repeat (3) @(negedge clk);
    #1; rst = 1'b1;
    #1;
    chk("F_busy", 64'(busy), 64'h0);
    chk("F_found", 64'(found), 64'h0);
    chk("F_exh", 64'(exhausted), 64'h0);
    chk("F_key", 64'(dec_key), 64'h0);
    chk("F_data", dec_data, 64'h0);
    @(negedge clk); #1; rst = 1'b0;

    // Same as the first sweep, with ena alternating 1/0
    sweep(48'h0, 48'hF, 64'h0123_4567_89AB_CDEF, 0, 1, cyc);
    chk("G_cycles", 64'(cyc), 64'd409);
    chk("G_pulses", 64'(pulses.size()), 64'd6);
    for (int i = 0; i < pulses.size(); i++) chk("G_key", 64'(pulses[i]), 64'(i));
    chk("G_found", 64'(found), 64'h1);
    chk("G_keyfound", 64'(key_found), 64'h5);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
